// File: rtl/timer_bus_if_if.sv
// ---------------------------------------------------------------------------
// timer_bus_if_if
// Simple request/ready data bus between the core (master) and the machine
// timer register front-end (slave).
//   bus_req    master -> slave  access request
//   bus_we     master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  byte address
//   bus_wdata  master -> slave  write data
//   bus_ready  slave -> master  access accepted when bus_req & bus_ready
//   bus_rvalid slave -> master  read data valid (one-cycle pulse)
//   bus_rdata  slave -> master  read data
//   bus_err    slave -> master  illegal-address pulse
// ---------------------------------------------------------------------------
interface timer_bus_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/timer_bus_if.sv
// ---------------------------------------------------------------------------
// timer_bus_if
// Memory-mapped register front-end for the machine timer.
//   - Bus writes become single-cycle write strobes toward the timer, with the
//     written data held stable until the next accepted write.
//   - 64-bit mtime reads are tear-free: reading MTIME_L latches the high word
//     into a shadow that MTIME_H returns.
//   - irq = tmr_int & ie.
//
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   bus              timer_bus_if_if.slave (request/ready data bus)
//   tmr_en           timer count enable value
//   tmr_wr_en        strobe: timer samples tmr_en
//   tmr_wr_cmp_l/h   strobes: timer samples tmr_cmp_l / tmr_cmp_h
//   tmr_cmp_l/h      mtimecmp low / high word
//   tmr_mtime_l/h    mtime from the timer
//   tmr_int          timer compare interrupt
//   irq              gated interrupt toward the core
//
// Parameter SETTLE_CYC (1..15): idle strobe cycles after each pulse before
// bus_ready returns.
//
// Optional feature macro TIMER_BUS_IF_ATOMIC_CMP_EN: MTIMECMP_L writes only
// load a staging register; an MTIMECMP_H write commits both halves at once
// and pulses both compare strobes together.
//
// Address map (addr[4:2]): 0 MTIME_L (ro), 1 MTIME_H (ro, shadow),
// 2 MTIMECMP_L, 3 MTIMECMP_H, 4 CTRL {PEND(ro), IE, EN}.
// ---------------------------------------------------------------------------
module timer_bus_if #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    timer_bus_if_if.slave        bus,
    output logic                 tmr_en,
    output logic                 tmr_wr_en,
    output logic                 tmr_wr_cmp_l,
    output logic                 tmr_wr_cmp_h,
    output logic [31:0]          tmr_cmp_l,
    output logic [31:0]          tmr_cmp_h,
    input  logic [31:0]          tmr_mtime_l,
    input  logic [31:0]          tmr_mtime_h,
    input  logic                 tmr_int,
    output logic                 irq
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE
    } state_t;

    localparam logic [2:0] SEL_MTIME_L = 3'd0;
    localparam logic [2:0] SEL_MTIME_H = 3'd1;
    localparam logic [2:0] SEL_CMP_L   = 3'd2;
    localparam logic [2:0] SEL_CMP_H   = 3'd3;
    localparam logic [2:0] SEL_CTRL    = 3'd4;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  settle_cnt;
    logic        ie;
    logic [31:0] mtime_h_shadow;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    logic        accept;
    logic [2:0]  sel;
    logic        bad;
    logic        wr_ok;
    logic        rd_ok;
    logic        wr_busy;
    logic [31:0] read_val;

`ifdef TIMER_BUS_IF_ATOMIC_CMP_EN
    logic [31:0] cmp_stage;
`endif

    assign accept = bus.bus_req && (state == IDLE);
    assign sel    = bus.bus_addr[4:2];
    assign bad    = (bus.bus_addr[1:0] != 2'b00) || (sel > SEL_CTRL) ||
                    (bus.bus_we && (sel < SEL_CMP_L));
    assign wr_ok  = accept && bus.bus_we && !bad;
    assign rd_ok  = accept && !bus.bus_we && !bad;

    // Staged low-word writes in atomic mode strobe nothing, so they do not
    // occupy the bus.
`ifdef TIMER_BUS_IF_ATOMIC_CMP_EN
    assign wr_busy = wr_ok && (sel != SEL_CMP_L);
`else
    assign wr_busy = wr_ok;
`endif

    assign bus.bus_ready  = (state == IDLE);
    assign bus.bus_rvalid = rvalid;
    assign bus.bus_err    = err;
    assign bus.bus_rdata  = rdata;
    assign irq            = tmr_int & ie;

    always_comb begin
        read_val = '0;
        case (sel)
            SEL_MTIME_L: read_val = tmr_mtime_l;
            SEL_MTIME_H: read_val = mtime_h_shadow;
            SEL_CMP_L:   read_val = tmr_cmp_l;
            SEL_CMP_H:   read_val = tmr_cmp_h;
            SEL_CTRL:    read_val = {29'd0, tmr_int, ie, tmr_en};
            default:     read_val = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_busy) state_nxt = PULSE;
            PULSE:   state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter is loaded while in PULSE so SETTLE lasts exactly SETTLE_CYC cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            settle_cnt <= '0;
        end else if (state == PULSE) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmr_en         <= 1'b0;
            ie             <= 1'b0;
            tmr_wr_en      <= 1'b0;
            tmr_wr_cmp_l   <= 1'b0;
            tmr_wr_cmp_h   <= 1'b0;
            tmr_cmp_l      <= '1;
            tmr_cmp_h      <= '1;
            mtime_h_shadow <= '0;
            rvalid         <= 1'b0;
            err            <= 1'b0;
            rdata          <= '0;
`ifdef TIMER_BUS_IF_ATOMIC_CMP_EN
            cmp_stage      <= '1;
`endif
        end else begin
            // Strobes are single-cycle; the following SETTLE window keeps
            // them from ever asserting on consecutive cycles.
            tmr_wr_en    <= 1'b0;
            tmr_wr_cmp_l <= 1'b0;
            tmr_wr_cmp_h <= 1'b0;
            rvalid       <= accept && !bus.bus_we;
            err          <= accept && bad;

            if (accept && bad && !bus.bus_we) begin
                rdata <= '0;
            end

            if (rd_ok) begin
                rdata <= read_val;
                if (sel == SEL_MTIME_L) begin
                    mtime_h_shadow <= tmr_mtime_h;
                end
            end

            if (wr_ok) begin
                case (sel)
                    SEL_CMP_L: begin
`ifdef TIMER_BUS_IF_ATOMIC_CMP_EN
                        cmp_stage    <= bus.bus_wdata;
`else
                        tmr_cmp_l    <= bus.bus_wdata;
                        tmr_wr_cmp_l <= 1'b1;
`endif
                    end
                    SEL_CMP_H: begin
                        tmr_cmp_h    <= bus.bus_wdata;
                        tmr_wr_cmp_h <= 1'b1;
`ifdef TIMER_BUS_IF_ATOMIC_CMP_EN
                        tmr_cmp_l    <= cmp_stage;
                        tmr_wr_cmp_l <= 1'b1;
`endif
                    end
                    SEL_CTRL: begin
                        tmr_en    <= bus.bus_wdata[0];
                        ie        <= bus.bus_wdata[1];
                        tmr_wr_en <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_bus_if.sv
// ---------------------------------------------------------------------------
// tb_timer_bus_if
// Self-checking bench for timer_bus_if. A register-level reference model
// (plain variables updated by the address-map rules) predicts read data,
// error pulses, strobe patterns, bus occupancy and timer-side outputs.
// ---------------------------------------------------------------------------
module tb_timer_bus_if;

    localparam int S = 2;

    logic        CLK;
    logic        RST_N;
    logic        tmr_en;
    logic        tmr_wr_en;
    logic        tmr_wr_cmp_l;
    logic        tmr_wr_cmp_h;
    logic [31:0] tmr_cmp_l;
    logic [31:0] tmr_cmp_h;
    logic [31:0] tmr_mtime_l;
    logic [31:0] tmr_mtime_h;
    logic        tmr_int;
    logic        irq;

    timer_bus_if_if bus_i ();

    timer_bus_if #(.SETTLE_CYC(S)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .bus          (bus_i),
        .tmr_en       (tmr_en),
        .tmr_wr_en    (tmr_wr_en),
        .tmr_wr_cmp_l (tmr_wr_cmp_l),
        .tmr_wr_cmp_h (tmr_wr_cmp_h),
        .tmr_cmp_l    (tmr_cmp_l),
        .tmr_cmp_h    (tmr_cmp_h),
        .tmr_mtime_l  (tmr_mtime_l),
        .tmr_mtime_h  (tmr_mtime_h),
        .tmr_int      (tmr_int),
        .irq          (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

`ifdef TIMER_BUS_IF_ATOMIC_CMP_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif

    // Reference model state
    logic [31:0] m_cmp_l, m_cmp_h, m_stage, m_shadow;
    logic        m_en, m_ie;

    task automatic model_reset();
        m_cmp_l  = 32'hFFFF_FFFF;
        m_cmp_h  = 32'hFFFF_FFFF;
        m_stage  = 32'hFFFF_FFFF;
        m_shadow = 32'h0;
        m_en     = 1'b0;
        m_ie     = 1'b0;
    endtask

    // One bus access. Returns the cycle-after-accept observations, the number
    // of cycles bus_ready stayed low, and how many of those cycles had a strobe.
    task automatic do_access(input logic we, input logic [4:0] addr,
                             input logic [31:0] wd,
                             output logic rv, output logic er,
                             output logic [31:0] rd, output logic [2:0] strb,
                             output int busy, output int pulses,
                             output logic timeout);
        rv = 1'b0; er = 1'b0; rd = '0; strb = '0;
        busy = 0; pulses = 0; timeout = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 50 && !bus_i.bus_ready; i++) @(negedge CLK);
        if (!bus_i.bus_ready) begin
            timeout = 1'b1;
            return;
        end
        bus_i.bus_req   = 1'b1;
        bus_i.bus_we    = we;
        bus_i.bus_addr  = addr;
        bus_i.bus_wdata = wd;
        @(posedge CLK);
        #1;
        rv   = bus_i.bus_rvalid;
        er   = bus_i.bus_err;
        rd   = bus_i.bus_rdata;
        strb = {tmr_wr_en, tmr_wr_cmp_l, tmr_wr_cmp_h};
        bus_i.bus_req = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 50; i++) begin
            if (bus_i.bus_ready) break;
            busy++;
            if (tmr_wr_en || tmr_wr_cmp_l || tmr_wr_cmp_h) pulses++;
            @(negedge CLK);
        end
        if (!bus_i.bus_ready) timeout = 1'b1;
    endtask

    task automatic test_reset();
        logic rv, er, to; logic [31:0] rd; logic [2:0] st; int bz, pu;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        @(negedge CLK);
        total++;
        if ({bus_i.bus_ready, bus_i.bus_rvalid, bus_i.bus_err, irq, tmr_en,
             tmr_wr_en, tmr_wr_cmp_l, tmr_wr_cmp_h} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_ctrl_bits got=%b exp=10000000",
                     {bus_i.bus_ready, bus_i.bus_rvalid, bus_i.bus_err, irq,
                      tmr_en, tmr_wr_en, tmr_wr_cmp_l, tmr_wr_cmp_h});
        end
        total++;
        if ({tmr_cmp_h, tmr_cmp_l} !== 64'hFFFF_FFFF_FFFF_FFFF || bus_i.bus_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_cmp got=%h_%h rdata=%h exp=ffffffff_ffffffff rdata=0",
                     tmr_cmp_h, tmr_cmp_l, bus_i.bus_rdata);
        end
        do_access(1'b0, 5'h10, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL reset_read_ctrl rv=%b err=%b rdata=%h to=%b exp rv=1 err=0 rdata=0",
                     rv, er, rd, to);
        end
        do_access(1'b0, 5'h0C, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || rv !== 1'b1 || rd !== 32'hFFFF_FFFF || bz != 0) begin
            bad++;
            $display("FAIL reset_read_cmph rv=%b rdata=%h busy=%0d exp rv=1 rdata=ffffffff busy=0",
                     rv, rd, bz);
        end
    endtask

    task automatic test_ctrl();
        logic rv, er, to; logic [31:0] rd; logic [2:0] st; int bz, pu;
        do_access(1'b1, 5'h10, 32'h3, rv, er, rd, st, bz, pu, to);
        m_en = 1'b1; m_ie = 1'b1;
        total++;
        if (to || st !== 3'b100 || bz != 1 + S || pu != 1 || er !== 1'b0 || rv !== 1'b0) begin
            bad++;
            $display("FAIL ctrl_write strb=%b busy=%0d pulses=%0d err=%b rv=%b exp strb=100 busy=%0d pulses=1 err=0 rv=0",
                     st, bz, pu, er, rv, 1 + S);
        end
        total++;
        if (tmr_en !== 1'b1) begin
            bad++;
            $display("FAIL ctrl_en got=%b exp=1", tmr_en);
        end
        tmr_int = 1'b0;
        do_access(1'b0, 5'h10, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || rd !== 32'h3 || irq !== 1'b0) begin
            bad++;
            $display("FAIL ctrl_read0 rdata=%h irq=%b exp rdata=3 irq=0", rd, irq);
        end
        tmr_int = 1'b1;
        do_access(1'b0, 5'h10, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || rd !== 32'h7 || irq !== 1'b1) begin
            bad++;
            $display("FAIL ctrl_read1 rdata=%h irq=%b exp rdata=7 irq=1", rd, irq);
        end
        tmr_int = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_follow got=%b exp=0", irq);
        end
    endtask

    task automatic test_mtime_shadow();
        logic rv, er, to; logic [31:0] rd; logic [2:0] st; int bz, pu;
        tmr_mtime_h = 32'h1; tmr_mtime_l = 32'hFFFF_FFFF;
        do_access(1'b0, 5'h00, 32'h0, rv, er, rd, st, bz, pu, to);
        m_shadow = 32'h1;
        total++;
        if (to || rd !== 32'hFFFF_FFFF || rv !== 1'b1) begin
            bad++;
            $display("FAIL mtime_l rdata=%h rv=%b exp rdata=ffffffff rv=1", rd, rv);
        end
        tmr_mtime_h = 32'h2; tmr_mtime_l = 32'h0;
        do_access(1'b0, 5'h04, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || rd !== 32'h1) begin
            bad++;
            $display("FAIL mtime_h_shadow rdata=%h exp=1", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic rv, er, to; logic [31:0] rd; logic [2:0] st; int bz, pu;
        do_access(1'b1, 5'h08, 32'h10, rv, er, rd, st, bz, pu, to);
        total++;
        if (ATOMIC) begin
            m_stage = 32'h10;
            if (to || st !== 3'b000 || bz != 0 || tmr_cmp_l !== 32'hFFFF_FFFF) begin
                bad++;
                $display("FAIL cmpl_stage strb=%b busy=%0d cmp_l=%h exp strb=000 busy=0 cmp_l=ffffffff",
                         st, bz, tmr_cmp_l);
            end
        end else begin
            m_cmp_l = 32'h10;
            if (to || st !== 3'b010 || bz != 1 + S || pu != 1) begin
                bad++;
                $display("FAIL cmpl_write strb=%b busy=%0d pulses=%0d exp strb=010 busy=%0d pulses=1",
                         st, bz, pu, 1 + S);
            end
        end
        do_access(1'b1, 5'h0C, 32'h0, rv, er, rd, st, bz, pu, to);
        m_cmp_h = 32'h0;
        if (ATOMIC) m_cmp_l = m_stage;
        total++;
        if (to || st !== (ATOMIC ? 3'b011 : 3'b001) || bz != 1 + S || pu != 1) begin
            bad++;
            $display("FAIL cmph_write strb=%b busy=%0d pulses=%0d exp strb=%b busy=%0d pulses=1",
                     st, bz, pu, (ATOMIC ? 3'b011 : 3'b001), 1 + S);
        end
        total++;
        if ({tmr_cmp_h, tmr_cmp_l} !== 64'h0000_0000_0000_0010) begin
            bad++;
            $display("FAIL cmp_value got=%h_%h exp=00000000_00000010", tmr_cmp_h, tmr_cmp_l);
        end
    endtask

    task automatic test_error();
        logic rv, er, to; logic [31:0] rd; logic [2:0] st; int bz, pu;
        do_access(1'b0, 5'h02, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || er !== 1'b1 || rv !== 1'b1 || rd !== 32'h0 || st !== 3'b000 || bz != 0) begin
            bad++;
            $display("FAIL err_read err=%b rv=%b rdata=%h strb=%b busy=%0d exp err=1 rv=1 rdata=0 strb=000 busy=0",
                     er, rv, rd, st, bz);
        end
        do_access(1'b1, 5'h14, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || er !== 1'b1 || rv !== 1'b0 || st !== 3'b000 || bz != 0 || pu != 0) begin
            bad++;
            $display("FAIL err_write err=%b rv=%b strb=%b busy=%0d exp err=1 rv=0 strb=000 busy=0",
                     er, rv, st, bz);
        end
        do_access(1'b1, 5'h00, 32'hFFFF_FFFF, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || er !== 1'b1 || st !== 3'b000 || bz != 0) begin
            bad++;
            $display("FAIL err_ro_write err=%b strb=%b busy=%0d exp err=1 strb=000 busy=0", er, st, bz);
        end
        do_access(1'b0, 5'h10, 32'h0, rv, er, rd, st, bz, pu, to);
        total++;
        if (to || er !== 1'b0 || rd !== {29'd0, tmr_int, m_ie, m_en}) begin
            bad++;
            $display("FAIL err_ctrl_kept err=%b rdata=%h exp err=0 rdata=%h",
                     er, rd, {29'd0, tmr_int, m_ie, m_en});
        end
    endtask

    task automatic test_random();
        logic rv, er, to; logic [31:0] rd; logic [2:0] st; int bz, pu;
        logic we; logic [4:0] addr; logic [31:0] wd;
        logic [2:0] sel; logic e_bad; logic [31:0] e_rd; logic [2:0] e_st; int e_bz;
        for (int n = 0; n < 80; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wd   = $urandom;
            tmr_mtime_l = $urandom;
            tmr_mtime_h = $urandom;
            tmr_int     = 1'($urandom_range(0, 1));
            sel   = addr[4:2];
            e_bad = (addr[1:0] != 2'b00) || (sel > 3'd4) || (we && sel < 3'd2);
            e_rd  = 32'h0;
            e_st  = 3'b000;
            e_bz  = 0;
            if (!we && !e_bad) begin
                case (sel)
                    3'd0: begin e_rd = tmr_mtime_l; end
                    3'd1: e_rd = m_shadow;
                    3'd2: e_rd = m_cmp_l;
                    3'd3: e_rd = m_cmp_h;
                    default: e_rd = {29'd0, tmr_int, m_ie, m_en};
                endcase
            end
            do_access(we, addr, wd, rv, er, rd, st, bz, pu, to);
            if (!we && !e_bad && sel == 3'd0) m_shadow = tmr_mtime_h;
            if (we && !e_bad) begin
                e_bz = 1 + S;
                case (sel)
                    3'd2: if (ATOMIC) begin m_stage = wd; e_bz = 0; end
                          else begin m_cmp_l = wd; e_st = 3'b010; end
                    3'd3: begin
                        m_cmp_h = wd;
                        e_st = 3'b001;
                        if (ATOMIC) begin m_cmp_l = m_stage; e_st = 3'b011; end
                    end
                    default: begin m_en = wd[0]; m_ie = wd[1]; e_st = 3'b100; end
                endcase
            end
            total++;
            if (to || er !== e_bad || rv !== !we || (!we && rd !== e_rd) ||
                st !== e_st || bz != e_bz || pu != (e_bz > 0 ? 1 : 0)) begin
                bad++;
                $display("FAIL rand_access n=%0d we=%b addr=%h err=%b rv=%b rdata=%h strb=%b busy=%0d pulses=%0d exp err=%b rv=%b rdata=%h strb=%b busy=%0d",
                         n, we, addr, er, rv, rd, st, bz, pu, e_bad, !we, e_rd, e_st, e_bz);
            end
            total++;
            if (tmr_cmp_l !== m_cmp_l || tmr_cmp_h !== m_cmp_h || tmr_en !== m_en ||
                irq !== (tmr_int & m_ie)) begin
                bad++;
                $display("FAIL rand_state n=%0d cmp=%h_%h en=%b irq=%b exp cmp=%h_%h en=%b irq=%b",
                         n, tmr_cmp_h, tmr_cmp_l, tmr_en, irq, m_cmp_h, m_cmp_l, m_en,
                         tmr_int & m_ie);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        @(negedge CLK);
        for (int i = 0; i < 50 && !bus_i.bus_ready; i++) @(negedge CLK);
        bus_i.bus_req   = 1'b1;
        bus_i.bus_we    = 1'b1;
        bus_i.bus_addr  = 5'h0C;
        bus_i.bus_wdata = 32'h1234_5678;
        @(posedge CLK);
        #1;
        bus_i.bus_req = 1'b0;
        total++;
        if (tmr_wr_cmp_h !== 1'b1 || tmr_cmp_h !== 32'h1234_5678 || bus_i.bus_ready !== 1'b0) begin
            bad++;
            $display("FAIL midpulse_pre strobe_h=%b cmp_h=%h ready=%b exp strobe_h=1 cmp_h=12345678 ready=0",
                     tmr_wr_cmp_h, tmr_cmp_h, bus_i.bus_ready);
        end
        RST_N = 1'b0;
        #1;
        model_reset();
        total++;
        if ({tmr_wr_en, tmr_wr_cmp_l, tmr_wr_cmp_h} !== 3'b000 || tmr_cmp_h !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL midpulse_drop strb=%b cmp_h=%h exp strb=000 cmp_h=ffffffff",
                     {tmr_wr_en, tmr_wr_cmp_l, tmr_wr_cmp_h}, tmr_cmp_h);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        total++;
        if (bus_i.bus_ready !== 1'b1 || tmr_wr_cmp_h !== 1'b0) begin
            bad++;
            $display("FAIL midpulse_release ready=%b strobe_h=%b exp ready=1 strobe_h=0",
                     bus_i.bus_ready, tmr_wr_cmp_h);
        end
    endtask

    initial begin
        RST_N           = 1'b0;
        bus_i.bus_req   = 1'b0;
        bus_i.bus_we    = 1'b0;
        bus_i.bus_addr  = '0;
        bus_i.bus_wdata = '0;
        tmr_mtime_l     = '0;
        tmr_mtime_h     = '0;
        tmr_int         = 1'b0;
        model_reset();
        test_reset();
        test_ctrl();
        test_mtime_shadow();
        test_back_to_back();
        test_error();
        test_random();
        test_reset_mid_pulse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
